// File: rtl/video_pkg.sv
// Shared definitions for the video pattern source.
//   TW           : width of every raster timing field and counter
//   MODE_*       : I_mode encodings (5..7 are reserved and render black)
//   fade_e       : fade direction states
//   bar_colour() : 8-entry colour-bar table, one bit per channel {R,G,B}
package video_pkg;

  localparam int unsigned TW = 12;

  localparam logic [2:0] MODE_FADE    = 3'd0;
  localparam logic [2:0] MODE_BARS    = 3'd1;
  localparam logic [2:0] MODE_CHECKER = 3'd2;
  localparam logic [2:0] MODE_RAMP    = 3'd3;
  localparam logic [2:0] MODE_SOLID   = 3'd4;

  typedef enum logic {
    FADE_UP,
    FADE_DOWN
  } fade_e;

  // W, Y, C, G, M, R, B, K from left to right
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running H/V counters plus the unregistered
// per-pixel terms derived from them.
//   i_pxl_clk, i_rst_n        : pixel clock, async active-low reset
//   i_h_* / i_v_*             : total, sync, back porch, active resolution
//   o_de, o_hs, o_vs          : active-video and active-high sync terms
//   o_x, o_y                  : 0-based active-area coordinates
//   o_frame_start             : counter state is (0,0)
module video_timing_gen
  import video_pkg::*;
(
  input  logic          i_pxl_clk,
  input  logic          i_rst_n,
  input  logic [TW-1:0] i_h_total,
  input  logic [TW-1:0] i_h_sync,
  input  logic [TW-1:0] i_h_bporch,
  input  logic [TW-1:0] i_h_res,
  input  logic [TW-1:0] i_v_total,
  input  logic [TW-1:0] i_v_sync,
  input  logic [TW-1:0] i_v_bporch,
  input  logic [TW-1:0] i_v_res,
  output logic          o_de,
  output logic          o_hs,
  output logic          o_vs,
  output logic [TW-1:0] o_x,
  output logic [TW-1:0] o_y,
  output logic          o_frame_start
);

  logic [TW-1:0] r_h_cnt, r_v_cnt;
  logic          w_h_wrap, w_v_wrap;
  logic [TW-1:0] w_h_start, w_v_start, w_h_end, w_v_end;

  // >= keeps the counters from running away if the totals shrink mid-frame
  assign w_h_wrap = r_h_cnt >= (i_h_total - TW'(1));
  assign w_v_wrap = r_v_cnt >= (i_v_total - TW'(1));

  always_ff @(posedge i_pxl_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + TW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + TW'(1);
    end
  end

  assign w_h_start = i_h_sync + i_h_bporch;
  assign w_v_start = i_v_sync + i_v_bporch;
  assign w_h_end   = w_h_start + i_h_res;
  assign w_v_end   = w_v_start + i_v_res;

  assign o_de = (r_h_cnt >= w_h_start) && (r_h_cnt < w_h_end) &&
                (r_v_cnt >= w_v_start) && (r_v_cnt < w_v_end);
  assign o_hs = r_h_cnt < i_h_sync;
  assign o_vs = r_v_cnt < i_v_sync;
  assign o_x  = r_h_cnt - w_h_start;
  assign o_y  = r_v_cnt - w_v_start;
  assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/video_pattern_gen.sv
// Raster timing plus multi-mode test pattern source (fade, colour bars,
// checkerboard, grey ramp, solid). All outputs leave through one register
// stage so DE, syncs and RGB are aligned on the same edge.
//   I_pxl_clk, I_rst_n          : pixel clock, async active-low reset
//   I_h_* / I_v_*               : raster timing (12 bits each)
//   I_hs_pol, I_vs_pol          : 1 = sync active-high
//   I_mode, I_solid_rgb         : pattern select / solid colour, taken at frame start
//   O_de, O_hs, O_vs            : active video and syncs with polarity applied
//   O_data_r/g/b                : pixel colour, zero outside active video
//   O_frame_start               : pulse with the outputs of pixel (0,0)
//   O_fps_toggle                : flips every FADE_FRAMES frames
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned CW          = 8,
  parameter int unsigned FADE_FRAMES = 30,
  parameter int unsigned CHK_LOG2    = 5
) (
  input  logic            I_pxl_clk,
  input  logic            I_rst_n,
  input  logic [TW-1:0]   I_h_total,
  input  logic [TW-1:0]   I_h_sync,
  input  logic [TW-1:0]   I_h_bporch,
  input  logic [TW-1:0]   I_h_res,
  input  logic [TW-1:0]   I_v_total,
  input  logic [TW-1:0]   I_v_sync,
  input  logic [TW-1:0]   I_v_bporch,
  input  logic [TW-1:0]   I_v_res,
  input  logic            I_hs_pol,
  input  logic            I_vs_pol,
  input  logic [2:0]      I_mode,
  input  logic [3*CW-1:0] I_solid_rgb,
  output logic            O_de,
  output logic            O_hs,
  output logic            O_vs,
  output logic [CW-1:0]   O_data_r,
  output logic [CW-1:0]   O_data_g,
  output logic [CW-1:0]   O_data_b,
  output logic            O_frame_start,
  output logic            O_fps_toggle
);

  localparam int unsigned   STEP_I  = ((2 ** CW) - 1) / (FADE_FRAMES - 1);
  localparam logic [CW-1:0] STEP    = CW'(STEP_I);
  localparam logic [CW-1:0] MAXV    = '1;
  localparam logic [7:0]    LAST_F  = 8'(FADE_FRAMES - 1);
  localparam logic [TW-1:0] CHK_BIT = TW'(1) << CHK_LOG2;

  logic          w_de, w_hs, w_vs, w_fs;
  logic [TW-1:0] w_x, w_y;

  video_timing_gen u_timing (
    .i_pxl_clk     (I_pxl_clk),
    .i_rst_n       (I_rst_n),
    .i_h_total     (I_h_total),
    .i_h_sync      (I_h_sync),
    .i_h_bporch    (I_h_bporch),
    .i_h_res       (I_h_res),
    .i_v_total     (I_v_total),
    .i_v_sync      (I_v_sync),
    .i_v_bporch    (I_v_bporch),
    .i_v_res       (I_v_res),
    .o_de          (w_de),
    .o_hs          (w_hs),
    .o_vs          (w_vs),
    .o_x           (w_x),
    .o_y           (w_y),
    .o_frame_start (w_fs)
  );

  // Frame-start state: mode/colour latch, fade FSM, frame counter
  logic [2:0]      r_mode;
  logic [3*CW-1:0] r_solid;
  logic [7:0]      r_fcnt;
  logic            r_tog;
  logic [CW-1:0]   r_level, w_level_nxt;
  fade_e           r_fade, w_fade_nxt;
  logic            w_last;

  assign w_last = r_fcnt == LAST_F;

  // The first frame of each half-period holds the endpoint reached by the
  // previous one (0 after reset), so each half is the mirror of the other.
  always_comb begin
    w_fade_nxt  = r_fade;
    w_level_nxt = r_level;
    if (w_fs) begin
      case (r_fade)
        FADE_UP: begin
          if (w_last) begin
            w_level_nxt = MAXV;
            w_fade_nxt  = FADE_DOWN;
          end else if (r_fcnt != '0) begin
            w_level_nxt = r_level + STEP;
          end
        end
        FADE_DOWN: begin
          if (w_last) begin
            w_level_nxt = '0;
            w_fade_nxt  = FADE_UP;
          end else if (r_fcnt != '0) begin
            w_level_nxt = r_level - STEP;
          end
        end
        default: w_fade_nxt = FADE_UP;
      endcase
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_fade  <= FADE_UP;
      r_level <= '0;
      r_fcnt  <= '0;
      r_tog   <= 1'b0;
      r_mode  <= MODE_FADE;
      r_solid <= '0;
    end else begin
      r_fade  <= w_fade_nxt;
      r_level <= w_level_nxt;
      if (w_fs) begin
        r_fcnt  <= w_last ? '0 : r_fcnt + 8'd1;
        r_tog   <= r_tog ^ w_last;
        r_mode  <= I_mode;
        r_solid <= I_solid_rgb;
      end
    end
  end

  // Pixel (0,0) is rendered with the values being latched on that same edge
  logic [2:0]      w_mode_eff;
  logic [3*CW-1:0] w_solid_eff;
  assign w_mode_eff  = w_fs ? I_mode      : r_mode;
  assign w_solid_eff = w_fs ? I_solid_rgb : r_solid;

  // Bar tracking: position within the current bar, restarted at x=0
  logic [2:0]    r_bar_idx, w_bar_idx;
  logic [TW-1:0] r_bar_pos, w_bar_pos, w_bar_w;
  logic [2:0]    w_bar_bits;

  assign w_bar_w   = I_h_res >> 3;
  assign w_bar_idx = (w_x == '0) ? '0 : r_bar_idx;
  assign w_bar_pos = (w_x == '0) ? '0 : r_bar_pos;
  assign w_bar_bits = bar_colour(w_bar_idx);

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_bar_idx <= '0;
      r_bar_pos <= '0;
    end else if (w_de) begin
      if (((w_bar_pos + TW'(1)) >= w_bar_w) && (w_bar_idx != 3'd7)) begin
        r_bar_idx <= w_bar_idx + 3'd1;
        r_bar_pos <= '0;
      end else begin
        r_bar_idx <= w_bar_idx;
        r_bar_pos <= w_bar_pos + TW'(1);
      end
    end
  end

  // Pattern mux; top-left checker square is white
  logic [3*CW-1:0] w_rgb;
  always_comb begin
    w_rgb = '0;
    if (w_de) begin
      case (w_mode_eff)
        MODE_FADE:    w_rgb = {w_level_nxt, MAXV - w_level_nxt, {CW{1'b0}}};
        MODE_BARS:    w_rgb = {{CW{w_bar_bits[2]}}, {CW{w_bar_bits[1]}}, {CW{w_bar_bits[0]}}};
        MODE_CHECKER: w_rgb = (((w_x ^ w_y) & CHK_BIT) == '0) ? '1 : '0;
        MODE_RAMP:    w_rgb = {3{w_x[CW-1:0]}};
        MODE_SOLID:   w_rgb = w_solid_eff;
        default:      w_rgb = '0;
      endcase
    end
  end

  // Output stage; sync polarity applied after the register so the reset
  // level follows the polarity inputs
  logic            r_de, r_hs_act, r_vs_act, r_fs;
  logic [3*CW-1:0] r_rgb;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_de     <= 1'b0;
      r_hs_act <= 1'b0;
      r_vs_act <= 1'b0;
      r_fs     <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_de     <= w_de;
      r_hs_act <= w_hs;
      r_vs_act <= w_vs;
      r_fs     <= w_fs;
      r_rgb    <= w_rgb;
    end
  end

  assign O_de          = r_de;
  assign O_hs          = r_hs_act ? I_hs_pol : ~I_hs_pol;
  assign O_vs          = r_vs_act ? I_vs_pol : ~I_vs_pol;
  assign O_data_r      = r_rgb[3*CW-1 -: CW];
  assign O_data_g      = r_rgb[2*CW-1 -: CW];
  assign O_data_b      = r_rgb[CW-1:0];
  assign O_frame_start = r_fs;
  assign O_fps_toggle  = r_tog;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: a raster model computed from the cycle index
// since reset release, checked every cycle, plus literal pins.
module tb_video_pattern_gen;

  localparam int FF = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] h_total, h_sync, h_bporch, h_res;
  logic [11:0] v_total, v_sync, v_bporch, v_res;
  logic        hs_pol, vs_pol;
  logic [2:0]  mode;
  logic [23:0] solid;
  logic        de, hs, vs, fs, tog;
  logic [7:0]  r, g, b;

  int n_vec = 0;
  int n_err = 0;
  int phase = 0;
  int ne    = 0;

  always #5 clk = ~clk;

  video_pattern_gen #(.CW(8), .FADE_FRAMES(FF), .CHK_LOG2(5)) dut (
    .I_pxl_clk(clk), .I_rst_n(rst_n),
    .I_h_total(h_total), .I_h_sync(h_sync), .I_h_bporch(h_bporch), .I_h_res(h_res),
    .I_v_total(v_total), .I_v_sync(v_sync), .I_v_bporch(v_bporch), .I_v_res(v_res),
    .I_hs_pol(hs_pol), .I_vs_pol(vs_pol), .I_mode(mode), .I_solid_rgb(solid),
    .O_de(de), .O_hs(hs), .O_vs(vs), .O_data_r(r), .O_data_g(g), .O_data_b(b),
    .O_frame_start(fs), .O_fps_toggle(tog)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_timing(input int ht, hsy, hbp, hr, vt, vsy, vbp, vr);
    h_total = 12'(ht); h_sync = 12'(hsy); h_bporch = 12'(hbp); h_res = 12'(hr);
    v_total = 12'(vt); v_sync = 12'(vsy); v_bporch = 12'(vbp); v_res = 12'(vr);
  endtask

  task automatic wait_to(input int target);
    while (ne < target) begin
      @(negedge clk);
      ne++;
    end
  endtask

  // Fade level of frame n: up half c*STEP, down half MAX-c*STEP, endpoints forced
  function automatic int fade_level(input int n);
    int c, step;
    c = n % FF;
    step = 255 / (FF - 1);
    if (((n / FF) % 2) == 0) return (c == FF - 1) ? 255 : c * step;
    else                     return (c == FF - 1) ? 0   : 255 - c * step;
  endfunction

  function automatic logic [23:0] bar_rgb(input int x, input int hres);
    int idx;
    idx = x / (hres / 8);
    if (idx > 7) idx = 7;
    case (idx)
      0: return 24'hffffff;
      1: return 24'hffff00;
      2: return 24'h00ffff;
      3: return 24'h00ff00;
      4: return 24'hff00ff;
      5: return 24'hff0000;
      6: return 24'h0000ff;
      default: return 24'h000000;
    endcase
  endfunction

  initial begin : compare
    int k, s, ft, n, pos, h, v, x, y, hst, vst, lvl;
    bit have, e_de, e_hs, e_vs, e_fs, e_tog;
    logic [2:0]  m_mode;
    logic [23:0] m_solid, e_rgb, a_rgb;
    k = 0; n = 0; pos = 0; h = 0; v = 0;
    m_mode = 3'd0; m_solid = '0;
    forever begin
      @(posedge clk);
      have = rst_n;
      if (rst_n) begin
        s = k; k++;
        ft  = int'(h_total) * int'(v_total);
        n   = s / ft;
        pos = s % ft;
        h   = pos % int'(h_total);
        v   = pos / int'(h_total);
        if (pos == 0) begin
          m_mode  = mode;
          m_solid = solid;
        end
      end else begin
        k = 0;
      end
      #2;
      a_rgb = {r, g, b};
      if (!have) begin
        chk("reset outputs", {de, hs, vs, fs, tog, a_rgb}, {1'b0, ~hs_pol, ~vs_pol, 1'b0, 1'b0, 24'h0});
      end else begin
        hst  = int'(h_sync) + int'(h_bporch);
        vst  = int'(v_sync) + int'(v_bporch);
        e_de = (h >= hst) && (h < hst + int'(h_res)) && (v >= vst) && (v < vst + int'(v_res));
        x = h - hst;
        y = v - vst;
        e_hs  = (h < int'(h_sync)) ? hs_pol : ~hs_pol;
        e_vs  = (v < int'(v_sync)) ? vs_pol : ~vs_pol;
        e_fs  = (pos == 0);
        e_tog = (((n + 1) / FF) % 2) != 0;
        e_rgb = '0;
        if (e_de) begin
          case (m_mode)
            3'd0: begin lvl = fade_level(n); e_rgb = {8'(lvl), 8'(255 - lvl), 8'h00}; end
            3'd1: e_rgb = bar_rgb(x, int'(h_res));
            3'd2: e_rgb = (((x / 32) + (y / 32)) % 2 == 0) ? 24'hffffff : 24'h0;
            3'd3: e_rgb = {3{8'(x % 256)}};
            3'd4: e_rgb = m_solid;
            default: e_rgb = '0;
          endcase
        end
        chk($sformatf("pixel n=%0d h=%0d v=%0d", n, h, v),
            {de, hs, vs, fs, tog, a_rgb}, {e_de, e_hs, e_vs, e_fs, e_tog, e_rgb});

        // Literal pins
        if (phase == 1) begin
          if (pos == 0 && n == 28) chk("tog frame 28", tog, 1'b0);
          if (pos == 0 && n == 29) chk("tog frame 29", tog, 1'b1);
          if (pos == 0 && n == 58) chk("tog frame 58", tog, 1'b1);
          if (pos == 0 && n == 59) chk("tog frame 59", tog, 1'b0);
          if (e_de && x == 0 && y == 0 && m_mode == 3'd0) begin
            if (n == 1)  chk("fade f1",  a_rgb, 24'h08f700);
            if (n == 28) chk("fade f28", a_rgb, 24'he01f00);
            if (n == 29) chk("fade f29", a_rgb, 24'hff0000);
            if (n == 59) chk("fade f59", a_rgb, 24'h00ff00);
          end
          if (e_de && x == 0 && y == 5 && n == 60) chk("fade kept after mode req", a_rgb, 24'h00ff00);
          if (e_de && x == 0 && y == 0 && n == 61) chk("bars next frame", a_rgb, 24'hffffff);
          if (e_de && x == 0 && y == 0 && n == 63) chk("mode 6 black", a_rgb, 24'h000000);
          if (e_de && x == 0 && y == 0 && n == 65) chk("solid", a_rgb, 24'h123456);
        end
        if (phase == 2) begin
          if (pos == 39) chk("hs last active clk", hs, 1'b1);
          if (pos == 40) chk("hs first idle clk", hs, 1'b0);
          if (e_de && y == 0 && m_mode == 3'd1) begin
            if (x == 159)  chk("bar x159",  a_rgb, 24'hffffff);
            if (x == 160)  chk("bar x160",  a_rgb, 24'hffff00);
            if (x == 1119) chk("bar x1119", a_rgb, 24'h0000ff);
            if (x == 1120) chk("bar x1120", a_rgb, 24'h000000);
            if (x == 1279) chk("bar x1279", a_rgb, 24'h000000);
          end
          if (e_de && y == 0 && m_mode == 3'd3) begin
            if (x == 255) chk("ramp x255", a_rgb, 24'hffffff);
            if (x == 256) chk("ramp x256", a_rgb, 24'h000000);
          end
        end
        if (phase == 3 && e_de && y == 0) begin
          if (x == 1119) chk("bar1283 x1119", a_rgb, 24'h0000ff);
          if (x == 1120) chk("bar1283 x1120", a_rgb, 24'h000000);
          if (x == 1282) chk("bar1283 x1282", a_rgb, 24'h000000);
        end
        if (phase == 4) begin
          if (pos == 0) chk("hs/vs active-low", {hs, vs}, 2'b00);
          if (e_de && x == 31 && y == 0)  chk("chk 31,0",  a_rgb, 24'hffffff);
          if (e_de && x == 32 && y == 0)  chk("chk 32,0",  a_rgb, 24'h000000);
          if (e_de && x == 32 && y == 32) chk("chk 32,32", a_rgb, 24'hffffff);
        end
      end
    end
  end

  initial begin : driver
    int c, c1, c2;
    // Phase 1: small raster (480 clk/frame), fade, mode changes, async reset
    set_timing(40, 4, 6, 24, 12, 2, 3, 6);
    hs_pol = 1'b1; vs_pol = 1'b1; mode = 3'd0; solid = 24'h0; phase = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; ne = 0;
    wait_to(60 * 480 + 7 * 40);
    mode = 3'd1;
    wait_to(62 * 480 + 3 * 40);
    mode = 3'd6;
    wait_to(64 * 480 + 3 * 40);
    mode = 3'd4; solid = 24'h123456;
    wait_to(65 * 480 + 6 * 40 + 21);
    chk("de before reset", {de, r, g, b}, {1'b1, 24'h123456});
    rst_n = 1'b0;
    #1;
    chk("async reset", {de, hs, vs, fs, tog, r, g, b}, {1'b0, ~hs_pol, ~vs_pol, 1'b0, 1'b0, 24'h0});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c = 0; c1 = -1; c2 = -1;
    while (c < 3 * 480 && c2 < 0) begin
      @(negedge clk);
      c++;
      if (fs) begin
        if (c1 < 0) c1 = c;
        else        c2 = c;
      end
    end
    chk("first frame_start delay", 64'(c1), 64'(1));
    chk("frame_start period", 64'(c2 - c1), 64'(480));

    // Phase 2: 720p line timing, bars then ramp
    @(negedge clk);
    rst_n = 1'b0; phase = 2;
    set_timing(1650, 40, 220, 1280, 4, 1, 1, 2);
    mode = 3'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ne = 0;
    wait_to(6600 + 3000);
    mode = 3'd3;
    wait_to(3 * 6600 + 10);

    // Phase 3: bars with h_res = 1283
    @(negedge clk);
    rst_n = 1'b0; phase = 3;
    set_timing(1650, 40, 220, 1283, 4, 1, 1, 2);
    mode = 3'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ne = 0;
    wait_to(6600 + 10);

    // Phase 4: checkerboard, active-low syncs
    @(negedge clk);
    rst_n = 1'b0; phase = 4;
    set_timing(80, 4, 4, 64, 40, 2, 2, 34);
    hs_pol = 1'b0; vs_pol = 1'b0; mode = 3'd2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ne = 0;
    wait_to(3200 + 10);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
